// File: rtl/timer_multi.sv
// Prescaled shared up-counter with N_CH compare/PWM/capture channels on a Wishbone slave.
// Latency: each access is acked one clk after strobe; read data is registered. Backpressure: none, the slave never stalls.
module timer_multi #(
   parameter int ADDR_WIDTH  = 8,
   parameter int CNT_WIDTH   = 32,
   parameter int PRESC_WIDTH = 16,
   parameter int N_CH        = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [31:0]           wb_dat_i,
   output logic [31:0]           wb_dat_o,
   input  logic                  wb_we,
   input  logic [3:0]            wb_sel,
   input  logic                  wb_stb,
   output logic                  wb_ack,
   input  logic [N_CH-1:0]       cap_i,
   output logic [N_CH-1:0]       pwm_o,
   output logic                  irq
);

   localparam logic [7:0]  CH_MASK = 8'((1 << N_CH) - 1);
   localparam logic [16:0] ST_MASK = {1'b1, CH_MASK, CH_MASK};

   logic                   en_q, en_d, oneshot_q, oneshot_d;
   logic [PRESC_WIDTH-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, period_q, period_d;
   logic [16:0]            status_q, status_d, irq_en_q, irq_en_d;
   logic [3:0]             ctrl_q [N_CH];
   logic [3:0]             ctrl_d [N_CH];
   logic [CNT_WIDTH-1:0]   cmp_q [N_CH];
   logic [CNT_WIDTH-1:0]   cmp_d [N_CH];
   logic [CNT_WIDTH-1:0]   cap_q [N_CH];
   logic [CNT_WIDTH-1:0]   cap_d [N_CH];
   logic [N_CH-1:0]        sync1_q, sync2_q, prev_q, prev_d, pwm_q, pwm_d;
   logic                   ack_q, ack_d, irq_q, irq_d;
   logic [31:0]            dat_q, dat_d;

   logic [5:0]      widx;
   logic            acc, wr, tick, addr_unused;
   logic [31:0]     rdata, wval;
   logic [16:0]     w1c, st_set;
   logic [N_CH-1:0] rise, fall;

   assign widx        = wb_addr[7:2];
   assign addr_unused = ^wb_addr[1:0];
   assign acc         = wb_stb & ~ack_q;
   assign wr          = acc & wb_we;
   assign tick        = en_q && (pcnt_q == presc_q);
   assign rise        = sync2_q & ~prev_q;
   assign fall        = ~sync2_q & prev_q;

   // rdata doubles as the zero-extended old value for byte-lane merging
   always_comb begin
      rdata = '0;
      case (widx)
         6'd0: rdata[1:0] = {oneshot_q, en_q};
         6'd1: rdata[PRESC_WIDTH-1:0] = presc_q;
         6'd2: rdata[CNT_WIDTH-1:0] = cnt_q;
         6'd3: rdata[CNT_WIDTH-1:0] = period_q;
         6'd4: rdata[16:0] = status_q;
         6'd5: rdata[16:0] = irq_en_q;
         default: ;
      endcase
      for (int n = 0; n < N_CH; n++) begin
         if (widx == 6'(16 + 4*n)) rdata[3:0] = ctrl_q[n];
         if (widx == 6'(17 + 4*n)) rdata[CNT_WIDTH-1:0] = cmp_q[n];
         if (widx == 6'(18 + 4*n)) rdata[CNT_WIDTH-1:0] = cap_q[n];
      end
      wval = rdata;
      for (int b = 0; b < 4; b++)
         if (wb_sel[b]) wval[8*b +: 8] = wb_dat_i[8*b +: 8];
      w1c = wb_dat_i[16:0] & {wb_sel[2], {8{wb_sel[1]}}, {8{wb_sel[0]}}};
   end

   always_comb begin
      en_d      = en_q;
      oneshot_d = oneshot_q;
      presc_d   = presc_q;
      pcnt_d    = pcnt_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      irq_en_d  = irq_en_q;
      ctrl_d    = ctrl_q;
      cmp_d     = cmp_q;
      cap_d     = cap_q;
      prev_d    = sync2_q;
      pwm_d     = pwm_q;
      st_set    = '0;

      if (en_q) pcnt_d = tick ? '0 : pcnt_q + PRESC_WIDTH'(1);
      if (tick) begin
         if (cnt_q == period_q) begin
            cnt_d      = '0;
            st_set[16] = 1'b1;
            if (oneshot_q) en_d = 1'b0;
         end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end
      end

      for (int n = 0; n < N_CH; n++) begin
         case (ctrl_q[n][1:0])
            2'b01: if (tick && cnt_q == cmp_q[n]) begin
               st_set[n] = 1'b1;
               pwm_d[n]  = ~pwm_q[n];
            end
            2'b10: pwm_d[n] = (cnt_q < cmp_q[n]);
            2'b11: begin
               pwm_d[n] = 1'b0;
               if ((ctrl_q[n][2] & rise[n]) | (ctrl_q[n][3] & fall[n])) begin
                  cap_d[n]      = cnt_q;
                  st_set[n]     = 1'b1;
                  st_set[8 + n] = status_q[n];
               end
            end
            default: pwm_d[n] = 1'b0;
         endcase
      end

      // bus writes come last so they override same-cycle hardware updates
      if (wr) begin
         case (widx)
            6'd0: begin
               en_d      = wval[0];
               oneshot_d = wval[1];
               if (wval[2]) begin
                  cnt_d  = '0;
                  pcnt_d = '0;
               end
            end
            6'd1: presc_d  = wval[PRESC_WIDTH-1:0];
            6'd2: cnt_d    = wval[CNT_WIDTH-1:0];
            6'd3: period_d = wval[CNT_WIDTH-1:0];
            6'd5: irq_en_d = wval[16:0] & ST_MASK;
            default: ;
         endcase
         for (int n = 0; n < N_CH; n++) begin
            if (widx == 6'(16 + 4*n)) begin
               ctrl_d[n] = wval[3:0];
               // seed history with the value arriving next cycle so a mode switch sees no edge
               if (wval[1:0] != ctrl_q[n][1:0]) prev_d[n] = sync1_q[n];
            end
            if (widx == 6'(17 + 4*n)) cmp_d[n] = wval[CNT_WIDTH-1:0];
         end
      end

      status_d = ((status_q & ~((wr && widx == 6'd4) ? w1c : 17'd0)) | st_set) & ST_MASK;
      irq_d    = |(status_q & irq_en_q);
      ack_d    = wb_stb & ~ack_q;
      dat_d    = acc ? rdata : dat_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q      <= 1'b0;
         oneshot_q <= 1'b0;
         presc_q   <= '0;
         pcnt_q    <= '0;
         cnt_q     <= '0;
         period_q  <= '1;
         status_q  <= '0;
         irq_en_q  <= '0;
         for (int n = 0; n < N_CH; n++) begin
            ctrl_q[n] <= '0;
            cmp_q[n]  <= '1;
            cap_q[n]  <= '0;
         end
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         pwm_q   <= '0;
         ack_q   <= 1'b0;
         irq_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         en_q      <= en_d;
         oneshot_q <= oneshot_d;
         presc_q   <= presc_d;
         pcnt_q    <= pcnt_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         status_q  <= status_d;
         irq_en_q  <= irq_en_d;
         ctrl_q    <= ctrl_d;
         cmp_q     <= cmp_d;
         cap_q     <= cap_d;
         sync1_q   <= cap_i;
         sync2_q   <= sync1_q;
         prev_q    <= prev_d;
         pwm_q     <= pwm_d;
         ack_q     <= ack_d;
         irq_q     <= irq_d;
         dat_q     <= dat_d;
      end
   end

   assign wb_ack   = ack_q;
   assign wb_dat_o = dat_q;
   assign pwm_o    = pwm_q;
   assign irq      = irq_q;

endmodule
